seg7_scan_decoder: RTL
======================

SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive identical samples needed to capture a digit; the legal range is 2..255.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Port seg, input, 7 bits: segment lines, active-high; bit6=a, bit5=b, ... bit0=g.
REQ-005 Port an, input, 4 bits: digit strobe, active-high; an[i] selects digit i.
REQ-006 Port scan_en, input, 1 bit: sampling enable.
REQ-007 Port out_ready, input, 1 bit: the consumer accepts out_bcd.
REQ-008 Port out_valid, output, 1 bit: out_bcd and out_err hold a complete frame.
REQ-009 Port out_bcd, output, 16 bits: decoded digits; digit i occupies [4i+3:4i].
REQ-010 Port out_err, output, 1 bit: at least one digit in the presented frame was an illegal or error pattern.
REQ-011 Port ovf, output, 1 bit: sticky overrun flag; a completed frame was dropped.

Function
REQ-012 The decode table, as seg value to nibble, SHALL be: 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9.
REQ-013 The error glyph 76 SHALL decode to nibble F and mark the digit as erroneous.
REQ-014 Any other seg value SHALL decode to nibble E and mark the digit as erroneous.
REQ-015 A sample is valid only when scan_en=1 and an is exactly one-hot.
- An invalid sample clears the stability counter.
- An invalid sample returns the FSM to WAIT.
REQ-016 The per-sample FSM SHALL have three states: WAIT, COUNT and HELD.
- WAIT: on a valid sample, register the {an, seg} pair, set count=1, go to COUNT.
- COUNT: a valid sample equal to the registered pair increments count.
- COUNT: a valid sample that differs re-registers the new pair, sets count=1 and stays in COUNT.
- COUNT: when the increment makes count equal STABLE_CYCLES, capture the digit and go to HELD.
- HELD: an equal sample causes no action, so each strobe episode captures only once.
- HELD: a differing valid sample behaves as in WAIT.
REQ-017 A capture SHALL write the decoded nibble and its error bit into slot i and set got[i].
- Recapturing a slot already set in the current frame overwrites it; the latest value wins.
REQ-018 Frame completion occurs at the clock edge where got becomes all-ones, counting the capture on that edge.
- out_bcd is loaded from the slots, including that capture.
- out_err is loaded as the OR of the four slot error bits.
- got is cleared.
- out_valid is 1 after that edge.
REQ-019 Capture latency: with a pair held stable for STABLE_CYCLES edges, the capture happens on the STABLE_CYCLES-th edge.
- If that capture completes the frame, out_valid rises at the same edge.
REQ-020 Handshake: out_valid, out_bcd and out_err SHALL hold stable while out_valid=1 and out_ready=0.
- A transfer occurs on an edge with out_valid=1 and out_ready=1.
- After a transfer with no new completion, out_valid=0.
REQ-021 When a completion and a transfer coincide on the same edge, the new frame SHALL load and out_valid SHALL stay 1.
REQ-022 When a completion occurs while out_valid=1 and out_ready=0:
- the new frame is discarded;
- the output registers are unchanged;
- got is cleared;
- ovf is set and stays 1 until rst.
REQ-023 out_ready SHALL have no effect while out_valid=0.
REQ-024 scan_en=0 SHALL NOT clear got or the slot contents.

Reset
REQ-025 On rst=1 at an edge, the following SHALL clear regardless of other inputs, including mid-count and mid-frame:
- FSM to WAIT, count=0, got=0, slots=0;
- out_valid=0, out_bcd=16'h0000, out_err=0, ovf=0.

Verification
REQ-026 Scan digits 0..3 with seg=79,6D,30,7E (an=0001,0010,0100,1000), each held 4 cycles, out_ready=1.
- Expect out_valid for exactly 1 cycle, at the 16th edge.
- Expect out_bcd=16'h0123 and out_err=0.
REQ-027 Hold each digit for only 3 cycles, then set an=0000 for 1 cycle.
- Expect no capture and out_valid never asserting.
REQ-028 Scan a frame containing seg=76 on digit 2 and seg=00 on digit 0.
- Expect out_bcd=16'h0F0E (digit1=0, digit3=0) and out_err=1.
REQ-029 Hold out_ready=0 and complete two frames.
- Expect the first frame held stable and ovf=1 after the second completion.
- Raise out_ready; expect a transfer of the first frame, then out_valid=0.
REQ-030 Complete a frame on the same edge that out_ready=1 accepts the pending frame.
- Expect out_valid to stay 1 with the new value and ovf=0.
REQ-031 Assert rst mid-count (digit at count 2) and again while out_valid=1.
- Expect all outputs zero on the next cycle.
- Expect a fresh frame to require the full 4 stable samples per digit.

Source files
------------

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - Debounced multiplexed 7-segment scan decoder.
// Captures stable {an, seg} strobes into BCD slots and presents whole frames on a ready/valid port.
module seg7_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  input  logic        scan_en,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_bcd,
  output logic        out_err,
  output logic        ovf
);

  localparam logic [7:0] LP_STABLE = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {S_WAIT, S_COUNT, S_HELD} state_t;

  state_t      r_state;
  logic [10:0] r_pair;
  logic [7:0]  r_count;
  logic [3:0]  r_got;
  logic [15:0] r_slots;
  logic [3:0]  r_slot_err;
  logic        r_out_valid;
  logic [15:0] r_out_bcd;
  logic        r_out_err;
  logic        r_ovf;

  logic        w_valid;
  logic        w_same;
  logic        w_capture;
  logic        w_complete;
  logic [3:0]  w_nibble;
  logic        w_digit_err;
  logic [15:0] w_slots_next;
  logic [3:0]  w_err_next;
  logic [3:0]  w_got_next;

  assign w_valid   = scan_en && (an != 4'd0) && ((an & (an - 4'd1)) == 4'd0);
  assign w_same    = ({an, seg} == r_pair);
  assign w_capture = w_valid && (r_state == S_COUNT) && w_same && ((r_count + 8'd1) == LP_STABLE);

  always_comb begin
    w_nibble    = 4'hE;
    w_digit_err = 1'b0;
    case (seg)
      7'h7E: w_nibble = 4'h0;
      7'h30: w_nibble = 4'h1;
      7'h6D: w_nibble = 4'h2;
      7'h79: w_nibble = 4'h3;
      7'h33: w_nibble = 4'h4;
      7'h5B: w_nibble = 4'h5;
      7'h5F: w_nibble = 4'h6;
      7'h70: w_nibble = 4'h7;
      7'h7F: w_nibble = 4'h8;
      7'h7B: w_nibble = 4'h9;
      7'h76: begin w_nibble = 4'hF; w_digit_err = 1'b1; end
      default: begin w_nibble = 4'hE; w_digit_err = 1'b1; end
    endcase
  end

  // Slot state as it will look after this edge, including a capture on this edge.
  always_comb begin
    w_slots_next = r_slots;
    w_err_next   = r_slot_err;
    w_got_next   = r_got;
    if (w_capture) begin
      for (int i = 0; i < 4; i++) begin
        if (an[i]) begin
          w_slots_next[4*i +: 4] = w_nibble;
          w_err_next[i]          = w_digit_err;
          w_got_next[i]          = 1'b1;
        end
      end
    end
  end

  assign w_complete = w_capture && (w_got_next == 4'hF);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_WAIT;
      r_pair      <= 11'd0;
      r_count     <= 8'd0;
      r_got       <= 4'd0;
      r_slots     <= 16'd0;
      r_slot_err  <= 4'd0;
      r_out_valid <= 1'b0;
      r_out_bcd   <= 16'd0;
      r_out_err   <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (!w_valid) begin
        r_state <= S_WAIT;
        r_count <= 8'd0;
      end else begin
        case (r_state)
          S_COUNT: begin
            if (w_same) begin
              r_count <= r_count + 8'd1;
              if ((r_count + 8'd1) == LP_STABLE) r_state <= S_HELD;
            end else begin
              r_pair  <= {an, seg};
              r_count <= 8'd1;
            end
          end
          S_HELD: begin
            if (!w_same) begin
              r_pair  <= {an, seg};
              r_count <= 8'd1;
              r_state <= S_COUNT;
            end
          end
          default: begin
            r_pair  <= {an, seg};
            r_count <= 8'd1;
            r_state <= S_COUNT;
          end
        endcase
      end

      r_slots    <= w_slots_next;
      r_slot_err <= w_err_next;
      r_got      <= w_complete ? 4'd0 : w_got_next;

      // A completed frame is dropped, not queued, when the previous one is still pending.
      if (w_complete) begin
        if (!r_out_valid || out_ready) begin
          r_out_valid <= 1'b1;
          r_out_bcd   <= w_slots_next;
          r_out_err   <= |w_err_next;
        end else begin
          r_ovf <= 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_bcd   = r_out_bcd;
  assign out_err   = r_out_err;
  assign ovf       = r_ovf;

endmodule
